// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave controller: FSM state encodings and
// a width helper used to size counters from their terminal counts.
package microwave_pkg;

    typedef enum logic [1:0] {
        MW_IDLE    = 2'd0,
        MW_COOKING = 2'd1,
        MW_PAUSED  = 2'd2,
        MW_DONE    = 2'd3
    } mw_state_e;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COOKING = 2'd1;
    localparam logic [1:0] ST_PAUSED  = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    // Bits needed to hold 0..n-1, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/magnetron_power_ctrl_if.sv
// Control/status bundle between the oven front panel and the magnetron
// power controller; state is exported for observation.
interface magnetron_power_ctrl_if #(
    parameter int TIME_W  = 12,
    parameter int PWR_MAX = 10
);
    localparam int PW_W = $clog2(PWR_MAX + 1);

    // No valid/ready handshake: all requests are levels sampled on every rising clk edge.
    logic              start;
    logic              stop;
    logic              clear;
    logic              door_closed;
    logic [TIME_W-1:0] time_in;
    logic [PW_W-1:0]   power_in;
    logic              mag_en;
    logic [TIME_W-1:0] time_left;
    logic [1:0]        state;
    logic              done;

    modport master (
        output start, stop, clear, door_closed, time_in, power_in,
        input  mag_en, time_left, state, done
    );

    modport slave (
        input  start, stop, clear, door_closed, time_in, power_in,
        output mag_en, time_left, state, done
    );

endinterface

// File: rtl/magnetron_duty_gen.sv
// Duty-window generator: PWR_MAX slots of SLOT_CYCLES each; o_slot_on is high
// while the current slot index is below the latched power level.
module magnetron_duty_gen
    import microwave_pkg::*;
#(
    parameter int PWR_MAX     = 10,
    parameter int SLOT_CYCLES = 100
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_run,
    input  logic                         i_clear,
    input  logic [$clog2(PWR_MAX+1)-1:0] i_power,
    output logic                         o_slot_on
);
    localparam int SLOT_W = cnt_w(SLOT_CYCLES);
    localparam int IDX_W  = cnt_w(PWR_MAX);
    localparam int PW_W   = $clog2(PWR_MAX + 1);

    logic [SLOT_W-1:0] r_slot_cnt;
    logic [IDX_W-1:0]  r_slot_idx;
    logic              w_slot_wrap;
    logic              w_idx_wrap;

    assign w_slot_wrap = (r_slot_cnt == SLOT_W'(SLOT_CYCLES - 1));
    assign w_idx_wrap  = (r_slot_idx == IDX_W'(PWR_MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_cnt <= '0;
            r_slot_idx <= '0;
        end else if (i_clear) begin
            r_slot_cnt <= '0;
            r_slot_idx <= '0;
        end else if (i_run) begin
            if (w_slot_wrap) begin
                r_slot_cnt <= '0;
                r_slot_idx <= w_idx_wrap ? '0 : r_slot_idx + 1'b1;
            end else begin
                r_slot_cnt <= r_slot_cnt + 1'b1;
            end
        end
    end

    assign o_slot_on = (PW_W'(r_slot_idx) < i_power);

endmodule

// File: rtl/magnetron_power_ctrl.sv
// Microwave cook controller: IDLE/COOKING/PAUSED/DONE FSM, per-second countdown
// and duty-cycled magnetron enable derived from the latched power level.
module magnetron_power_ctrl
    import microwave_pkg::*;
#(
    parameter int TIME_W      = 12,
    parameter int PWR_MAX     = 10,
    parameter int SLOT_CYCLES = 100,
    parameter int SEC_CYCLES  = 1000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    magnetron_power_ctrl_if.slave  bus
);
    localparam int PW_W  = $clog2(PWR_MAX + 1);
    localparam int SEC_W = cnt_w(SEC_CYCLES);

    logic [1:0]        r_state;
    logic [TIME_W-1:0] r_time_left;
    logic [PW_W-1:0]   r_power;
    logic [SEC_W-1:0]  r_sec_cnt;
    logic              r_done;

    logic w_start_ok;
    logic w_advance;
    logic w_sec_wrap;
    logic w_cnt_clear;
    logic w_slot_on;

    assign w_start_ok = bus.start && bus.door_closed && (bus.time_in != '0) &&
                        (bus.power_in != '0) && (bus.power_in <= PW_W'(PWR_MAX));
    // Counters only move in a COOKING cycle that stays COOKING, so a pause
    // (including one that lands on the final-second wrap) freezes the phase.
    assign w_advance   = (r_state == ST_COOKING) && !bus.clear && bus.door_closed && !bus.stop;
    assign w_sec_wrap  = (r_sec_cnt == SEC_W'(SEC_CYCLES - 1));
    assign w_cnt_clear = bus.clear || (r_state == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_time_left <= '0;
            r_power     <= '0;
            r_sec_cnt   <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.clear) begin
                r_state     <= ST_IDLE;
                r_time_left <= '0;
                r_sec_cnt   <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_start_ok) begin
                            r_state     <= ST_COOKING;
                            r_time_left <= bus.time_in;
                            r_power     <= bus.power_in;
                            r_sec_cnt   <= '0;
                        end
                    end
                    ST_COOKING: begin
                        if (!w_advance) begin
                            r_state <= ST_PAUSED;
                        end else if (w_sec_wrap) begin
                            r_sec_cnt <= '0;
                            if (r_time_left == TIME_W'(1)) begin
                                r_time_left <= '0;
                                r_state     <= ST_DONE;
                                r_done      <= 1'b1;
                            end else if (r_time_left != '0) begin
                                r_time_left <= r_time_left - 1'b1;
                            end
                        end else begin
                            r_sec_cnt <= r_sec_cnt + 1'b1;
                        end
                    end
                    ST_PAUSED: begin
                        if (bus.door_closed && !bus.stop && bus.start) begin
                            r_state <= ST_COOKING;
                        end
                    end
                    default: begin
                        if (bus.start || !bus.door_closed) begin
                            r_state <= ST_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    magnetron_duty_gen #(
        .PWR_MAX     (PWR_MAX),
        .SLOT_CYCLES (SLOT_CYCLES)
    ) u_duty_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_run     (w_advance),
        .i_clear   (w_cnt_clear),
        .i_power   (r_power),
        .o_slot_on (w_slot_on)
    );

    // door_closed gates the enable combinationally so an opening door cuts power at once.
    assign bus.mag_en    = (r_state == ST_COOKING) && w_slot_on && bus.door_closed;
    assign bus.time_left = r_time_left;
    assign bus.state     = r_state;
    assign bus.done      = r_done;

endmodule

// File: doc/magnetron_power_ctrl.md
MAGNETRON_POWER_CTRL -- requirements
Module: magnetron_power_ctrl

Interface
REQ-001 Parameter TIME_W, default 12, sets the width of cook time in seconds.
REQ-002 Parameter PWR_MAX, default 10, is the number of power levels and the number of slots per duty window.
REQ-003 Parameter SLOT_CYCLES, default 100, is the clock cycles per duty slot.
REQ-004 Parameter SEC_CYCLES, default 1000, is the clock cycles per second tick.
REQ-005 clk  in  1  is the single clock; all state updates occur on its rising edge.
REQ-006 rst_n  in  1  is the asynchronous, active-low reset.
REQ-007 start  in  1  is the start/resume request, level sampled each cycle.
REQ-008 stop  in  1  is the pause request.
REQ-009 clear  in  1  is the abort request; it zeroes the time.
REQ-010 door_closed  in  1  is 1 when the door is shut.
REQ-011 time_in  in  TIME_W  is the cook time in seconds, sampled on start from IDLE.
REQ-012 power_in  in  $clog2(PWR_MAX+1)  is the power level, 1..PWR_MAX, sampled on start from IDLE.
REQ-013 mag_en  out  1  is the magnetron enable.
REQ-014 time_left  out  TIME_W  is the remaining seconds.
REQ-015 state  out  2  is the FSM state encoding.
REQ-016 done  out  1  is a one-cycle pulse on cook completion.

Function
REQ-017 The FSM shall have the states IDLE=0, COOKING=1, PAUSED=2 and DONE=3.
REQ-018 Input priority each cycle shall be: clear > door open (door_closed=0) > stop > start.
REQ-019 clear in any state shall go to IDLE next cycle, with time_left=0 and both counters zeroed.
REQ-020 IDLE->COOKING shall require start=1, door_closed=1, time_in!=0 and power_in in 1..PWR_MAX; time_in and power_in are latched in that transition cycle.
REQ-021 A start from IDLE that fails any REQ-020 condition shall be ignored, with no state change.
REQ-022 COOKING->PAUSED shall occur on door_closed=0 or stop=1; the second and slot counters hold their values.
REQ-023 PAUSED->COOKING shall occur on start=1 with door_closed=1, resuming the counters where they stopped; the latched power is unchanged and time_in/power_in are ignored.
REQ-024 In COOKING, the second counter shall count 0..SEC_CYCLES-1; at wrap, time_left decrements by 1.
REQ-025 When time_left decrements from 1 to 0, the FSM shall go to DONE, with done=1 for exactly that cycle.
REQ-026 DONE->IDLE shall occur on clear, start, or door_closed=0; time_left stays 0.
REQ-027 In COOKING, the slot counter shall count 0..SLOT_CYCLES-1 and the slot index shall count 0..PWR_MAX-1, wrapping together.
REQ-028 mag_en shall equal (state==COOKING) AND (slot index < latched power) AND door_closed; door_closed acts combinationally, so mag_en drops in the same cycle the door opens.
REQ-029 A latched power of PWR_MAX shall give mag_en continuously high while COOKING; a latched power of 1 shall give a 1/PWR_MAX duty.
REQ-030 When stop and the final-second wrap occur in the same cycle, stop shall win: the FSM goes to PAUSED with time_left=1 and no decrement.
REQ-031 time_left shall never underflow below 0 or exceed the latched value.
REQ-032 mag_en shall be 0 in IDLE, PAUSED and DONE.

Reset
REQ-033 On rst_n=0, the block shall immediately set state=IDLE, time_left=0, mag_en=0, done=0, all counters to 0 and the latched power to 0, including during COOKING.
REQ-034 After rst_n deasserts, the first transition shall be possible on the next rising clk edge.

Structure
REQ-035 The state enum and state encodings shall live in the shared package microwave_pkg.
REQ-036 The duty-window generator (slot counter, slot index, compare) shall be the sub-module magnetron_duty_gen, with parameters PWR_MAX and SLOT_CYCLES and a run enable input.
REQ-037 Counter widths shall be derived with $clog2 from the parameters; there shall be no hard-coded widths.

Verification (PWR_MAX=4, SLOT_CYCLES=2, SEC_CYCLES=8, TIME_W=4)
REQ-038 Start with time_in=3, power_in=2, door closed -> COOKING; mag_en follows the pattern 4 on / 4 off; time_left goes 3,2,1 every 8 cycles; done pulses once at the 24th cycle; state=DONE.
REQ-039 Open the door mid-COOKING -> mag_en=0 in the same cycle; PAUSED; close the door and start -> resumes with unchanged time_left and counter phase.
REQ-040 Start with door open, or with time_in=0, or with power_in=0 -> stays IDLE, mag_en=0.
REQ-041 Assert stop and clear together in COOKING -> IDLE, time_left=0; stop alone -> PAUSED, mag_en=0.
REQ-042 power_in=4 -> mag_en continuously 1 while COOKING; power_in=5 -> start ignored.
REQ-043 Assert rst_n=0 mid-COOKING between clock edges -> all outputs are 0 and state=IDLE before the next edge.
